cw305_crypt_ctrl: RTL and testbench
===================================

Name: cw305_crypt_ctrl

Overview:
- Sequencer between the CW305 register block and a single-shot crypto core (load/busy/data style, e.g. AES-128).
- Latches key and plaintext on a start request, issues a one-cycle load, and tracks core busy to completion or timeout.
- Captures the ciphertext and reports done, error and cycle count.
- Generates the delay-programmable capture trigger for tio_trigger.
- Lives entirely in the crypto clock domain; the register block hands it already-synchronised controls.

Parameters:
- pPT_WIDTH, 128, plaintext width
- pCT_WIDTH, 128, ciphertext width
- pKEY_WIDTH, 128, key width
- pCNT_WIDTH, 16, width of timeout limit and cycle counter
- pDLY_WIDTH, 8, width of trigger delay

Ports:
- crypto_clk  in  1  sole clock
- resetn  in  1  asynchronous, active-low reset
- I_start  in  1  single-cycle start request
- I_abort  in  1  synchronous abort of the current job
- I_key  in  pKEY_WIDTH  key from register block
- I_textin  in  pPT_WIDTH  plaintext from register block
- I_timeout  in  pCNT_WIDTH  max job cycles; 0 = disabled
- I_trig_delay  in  pDLY_WIDTH  cycles from load to trigger rise
- O_ready  out  1  idle, will accept start
- O_busy  out  1  job in progress
- O_done  out  1  sticky: last job ended (ok or timeout)
- O_timeout_err  out  1  sticky: last job timed out
- O_cipherout  out  pCT_WIDTH  captured ciphertext
- O_cycles  out  pCNT_WIDTH  busy-high cycles of last job, saturating
- O_trigger  out  1  scope trigger
- O_core_load  out  1  one-cycle load to core
- O_core_key  out  pKEY_WIDTH  latched key
- O_core_data  out  pPT_WIDTH  latched plaintext
- I_core_busy  in  1  core busy
- I_core_data  in  pCT_WIDTH  core result

Behaviour:
- Reset (resetn low, async):
  - state IDLE; O_ready=1.
  - O_busy, O_done, O_timeout_err, O_trigger, O_core_load = 0.
  - O_cipherout, O_cycles, O_core_key, O_core_data = 0.
- States: IDLE, LOAD, RUN.
- IDLE:
  - O_ready=1, O_busy=0.
  - I_start=1 latches I_key/I_textin into O_core_key/O_core_data, clears O_done, O_timeout_err, job counter and seen_busy, then goes to LOAD.
- LOAD (exactly 1 cycle):
  - O_core_load=1, O_busy=1, then RUN.
  - The trigger delay counter starts here.
- RUN:
  - Each cycle with I_core_busy=1 sets seen_busy and increments the cycle count, saturating at all-ones.
  - Completion = I_core_busy=0 while seen_busy=1. On completion: O_cipherout<=I_core_data, O_cycles<=count, O_done<=1, go to IDLE. Outputs are valid and O_ready=1 in the following cycle.
- Timeout:
  - A job cycle counter runs from LOAD.
  - If I_timeout!=0 and the counter reaches I_timeout in RUN without completion: O_timeout_err<=1, O_done<=1, O_cipherout unchanged, O_cycles<=count, go to IDLE.
  - The core is not reset; the next load simply re-arms it.
- Trigger:
  - O_trigger rises I_trig_delay cycles after the LOAD cycle; delay 0 raises it in the first RUN cycle.
  - It is held until the cycle after completion, timeout or abort, then cleared.
  - If the job ends before the delay elapses, O_trigger never pulses.
- Abort:
  - I_abort in LOAD or RUN goes to IDLE next cycle and clears O_trigger.
  - O_done stays 0; O_cipherout and O_cycles are unchanged.
  - Abort has priority over completion and timeout in the same cycle.
  - In IDLE, abort has no effect.
- I_start outside IDLE is ignored (no queueing).
- I_start coincident with completion is ignored; software re-issues it after O_ready.
- I_key/I_textin changes after the start cycle do not affect the running job.
- Latency: start at cycle 0, load at cycle 1, RUN from cycle 2. With core busy cycles 2..N+1, done/ciphertext are visible at cycle N+3.

Decomposition:
- Package cw305_crypt_ctrl_pkg: state enum (IDLE/LOAD/RUN), encodings, counter saturation constant.
- Sub-module cw305_trig_delay: delay counter plus O_trigger set/clear, with inputs arm (LOAD), stop (end/abort) and delay.

Test Plan:
- Nominal: key=000102..0f, pt=00112233..ff, core busy 10 cycles → single load pulse at cycle 1; O_cipherout=69c4e0d8..c55a; O_cycles=10; O_done=1; O_ready=1 at cycle 13.
- Timeout: I_timeout=5, core holds busy high → O_timeout_err=1, O_done=1, O_cipherout unchanged, O_cycles=4 or 5 per counter spec, back in IDLE.
- Trigger: I_trig_delay=3, busy 10 cycles → O_trigger rises 3 cycles after load and falls the cycle after completion. I_trig_delay=20 → O_trigger never asserts.
- Start during RUN and start coincident with completion → no second load pulse, O_cipherout from first job only. Abort in RUN → IDLE, O_done=0, trigger low.
- Async resetn low mid-RUN → all outputs at reset values immediately. Post-reset start runs normally.
- Saturation: pCNT_WIDTH=4, busy 20 cycles, I_timeout=0 → O_cycles=15, O_done=1, no error.

Source files
------------

// File: rtl/cw305_crypt_ctrl_pkg.sv
// Shared types and helpers for the CW305 crypto sequencer.
// Holds the FSM state encoding and the saturating-counter limit helper.
package cw305_crypt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int unsigned MaxCntWidth = 32;

    // All-ones value for a counter of the given width, used as the saturation point.
    function automatic logic [MaxCntWidth-1:0] satLimit(input int unsigned width);
        if (width >= MaxCntWidth) begin
            return '1;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/cw305_crypt_ctrl_if.sv
// Register-block and crypto-core signals of the sequencer, bundled as one interface.
// The slave modport is the sequencer; the master side is the register block plus core.
interface cw305_crypt_ctrl_if #(
    parameter int pPT_WIDTH  = 128,
    parameter int pCT_WIDTH  = 128,
    parameter int pKEY_WIDTH = 128,
    parameter int pCNT_WIDTH = 16,
    parameter int pDLY_WIDTH = 8
);
    logic                  I_start;
    logic                  I_abort;
    logic [pKEY_WIDTH-1:0] I_key;
    logic [pPT_WIDTH-1:0]  I_textin;
    logic [pCNT_WIDTH-1:0] I_timeout;
    logic [pDLY_WIDTH-1:0] I_trig_delay;
    logic                  O_ready;
    logic                  O_busy;
    logic                  O_done;
    logic                  O_timeout_err;
    logic [pCT_WIDTH-1:0]  O_cipherout;
    logic [pCNT_WIDTH-1:0] O_cycles;
    logic                  O_trigger;
    logic                  O_core_load;
    logic [pKEY_WIDTH-1:0] O_core_key;
    logic [pPT_WIDTH-1:0]  O_core_data;
    logic                  I_core_busy;
    logic [pCT_WIDTH-1:0]  I_core_data;

    modport slave (
        input  I_start, I_abort, I_key, I_textin, I_timeout, I_trig_delay,
        input  I_core_busy, I_core_data,
        output O_ready, O_busy, O_done, O_timeout_err, O_cipherout, O_cycles,
        output O_trigger, O_core_load, O_core_key, O_core_data
    );

    modport master (
        output I_start, I_abort, I_key, I_textin, I_timeout, I_trig_delay,
        output I_core_busy, I_core_data,
        input  O_ready, O_busy, O_done, O_timeout_err, O_cipherout, O_cycles,
        input  O_trigger, O_core_load, O_core_key, O_core_data
    );

endinterface

// File: rtl/cw305_crypt_ctrl_trig.sv
// Programmable-delay scope trigger: armed on the load cycle, held until the job stops.
// A stop in the same cycle as arm wins, so an aborted load never fires.
module cw305_trig_delay #(
    parameter int pDLY_WIDTH = 8
) (
    input  logic                  crypto_clk,
    input  logic                  resetn,
    input  logic                  arm_i,
    input  logic                  stop_i,
    input  logic [pDLY_WIDTH-1:0] delay_i,
    output logic                  trigger_o
);

    logic [pDLY_WIDTH-1:0] cnt_q;
    logic                  pending_q;
    logic                  trig_q;

    // Delay 0 fires straight from the arm cycle; otherwise count down delay-1 extra cycles.
    always_ff @(posedge crypto_clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
            trig_q    <= 1'b0;
        end else if (stop_i) begin
            pending_q <= 1'b0;
            trig_q    <= 1'b0;
        end else if (arm_i) begin
            trig_q <= 1'b0;
            if (delay_i == '0) begin
                pending_q <= 1'b0;
                trig_q    <= 1'b1;
            end else begin
                cnt_q     <= delay_i - 1'b1;
                pending_q <= 1'b1;
            end
        end else if (pending_q) begin
            if (cnt_q == '0) begin
                pending_q <= 1'b0;
                trig_q    <= 1'b1;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign trigger_o = trig_q;

endmodule

// File: rtl/cw305_crypt_ctrl.sv
// Sequencer between the CW305 register block and a single-shot crypto core.
// Latches key/plaintext, pulses load, tracks core busy to completion, timeout or abort.
module cw305_crypt_ctrl
    import cw305_crypt_ctrl_pkg::*;
#(
    parameter int pPT_WIDTH  = 128,
    parameter int pCT_WIDTH  = 128,
    parameter int pKEY_WIDTH = 128,
    parameter int pCNT_WIDTH = 16,
    parameter int pDLY_WIDTH = 8
) (
    input  logic              crypto_clk,
    input  logic              resetn,
    cw305_crypt_ctrl_if.slave bus
);

    localparam logic [pCNT_WIDTH-1:0] CntSat = pCNT_WIDTH'(satLimit(pCNT_WIDTH));

    state_t                state_q;
    logic                  ready_q, busy_q, done_q, toErr_q, load_q, seenBusy_q;
    logic [pCT_WIDTH-1:0]  cipher_q;
    logic [pCNT_WIDTH-1:0] cycles_q, cycleCnt_q, jobCnt_q;
    logic [pCNT_WIDTH-1:0] cycleCnt_d, jobCnt_d;
    logic [pKEY_WIDTH-1:0] key_q;
    logic [pPT_WIDTH-1:0]  data_q;
    logic                  abortJob, complete, timedOut, jobEnd;

    // cycleCnt_d already includes the current busy cycle, so a timeout reports it too.
    always_comb begin
        cycleCnt_d = cycleCnt_q;
        if (bus.I_core_busy && (cycleCnt_q != CntSat)) begin
            cycleCnt_d = cycleCnt_q + 1'b1;
        end
        jobCnt_d = (jobCnt_q != CntSat) ? jobCnt_q + 1'b1 : jobCnt_q;
        abortJob = (state_q != ST_IDLE) && bus.I_abort;
        complete = (state_q == ST_RUN) && seenBusy_q && !bus.I_core_busy;
        timedOut = (state_q == ST_RUN) && !complete && (bus.I_timeout != '0)
                   && (jobCnt_q == bus.I_timeout);
        jobEnd   = abortJob || complete || timedOut;
    end

    always_ff @(posedge crypto_clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            toErr_q    <= 1'b0;
            load_q     <= 1'b0;
            seenBusy_q <= 1'b0;
            cipher_q   <= '0;
            cycles_q   <= '0;
            cycleCnt_q <= '0;
            jobCnt_q   <= '0;
            key_q      <= '0;
            data_q     <= '0;
        end else begin
            load_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.I_start) begin
                        key_q      <= bus.I_key;
                        data_q     <= bus.I_textin;
                        done_q     <= 1'b0;
                        toErr_q    <= 1'b0;
                        jobCnt_q   <= '0;
                        cycleCnt_q <= '0;
                        seenBusy_q <= 1'b0;
                        load_q     <= 1'b1;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    jobCnt_q <= jobCnt_d;
                    if (abortJob) begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    jobCnt_q <= jobCnt_d;
                    // Abort outranks completion and timeout when they coincide.
                    if (abortJob) begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (complete || timedOut) begin
                        if (complete) begin
                            cipher_q <= bus.I_core_data;
                        end
                        toErr_q  <= timedOut;
                        cycles_q <= cycleCnt_d;
                        done_q   <= 1'b1;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        cycleCnt_q <= cycleCnt_d;
                        if (bus.I_core_busy) begin
                            seenBusy_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    cw305_trig_delay #(.pDLY_WIDTH(pDLY_WIDTH)) uTrig (
        .crypto_clk (crypto_clk),
        .resetn     (resetn),
        .arm_i      (state_q == ST_LOAD),
        .stop_i     (jobEnd),
        .delay_i    (bus.I_trig_delay),
        .trigger_o  (bus.O_trigger)
    );

    assign bus.O_ready       = ready_q;
    assign bus.O_busy        = busy_q;
    assign bus.O_done        = done_q;
    assign bus.O_timeout_err = toErr_q;
    assign bus.O_cipherout   = cipher_q;
    assign bus.O_cycles      = cycles_q;
    assign bus.O_core_load   = load_q;
    assign bus.O_core_key    = key_q;
    assign bus.O_core_data   = data_q;

endmodule

// File: tb/tb_cw305_crypt_ctrl.sv
// Directed self-checking bench for cw305_crypt_ctrl with a small busy/data core responder.
// A second instance with a 4-bit counter covers cycle-count saturation.
module tb_cw305_crypt_ctrl;

   localparam logic [127:0] Key  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] Pt   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] Ct   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] Junk = 128'hdeaddeaddeaddeaddeaddeaddeaddead;

   logic clock = 1'b0;
   logic resetn = 1'b0;
   int cycleNum = 0;
   int startCyc = 0;
   int checkCount = 0;
   int passCount = 0;
   int failCount = 0;

   logic coreArmed = 1'b0;
   int coreLeft = 0;
   int busyLen = 10;
   logic holdBusy = 1'b0;
   logic coreKill = 1'b0;
   logic [127:0] coreResult = Ct;

   logic trigPrev = 1'b0;
   int riseCyc = 0;
   int fallCyc = 0;
   int trigRises = 0;
   int loadCount = 0;

   cw305_crypt_ctrl_if bus ();
   cw305_crypt_ctrl_if #(.pCNT_WIDTH(4)) busS ();

   cw305_crypt_ctrl dut (
      .crypto_clk (clock),
      .resetn     (resetn),
      .bus        (bus)
   );

   cw305_crypt_ctrl #(.pCNT_WIDTH(4)) dutSat (
      .crypto_clk (clock),
      .resetn     (resetn),
      .bus        (busS)
   );

   // Free-running clock and a cycle index that the tasks use to time their checks.
   always #5 clock = ~clock;

   always @(posedge clock) cycleNum <= cycleNum + 1;

   // Core responder: goes busy the cycle after load, holds busyLen cycles, then shows the result.
   always @(negedge clock) begin
      if (coreKill) begin
         coreArmed = 1'b0;
         bus.I_core_busy = 1'b0;
      end else if (coreArmed) begin
         coreArmed = 1'b0;
         bus.I_core_busy = 1'b1;
         bus.I_core_data = Junk;
         coreLeft = busyLen;
      end else if (bus.I_core_busy && !holdBusy) begin
         coreLeft = coreLeft - 1;
         if (coreLeft <= 0) begin
            bus.I_core_busy = 1'b0;
            bus.I_core_data = coreResult;
         end
      end
      if (bus.O_core_load && !coreKill) coreArmed = 1'b1;
   end

   // Watches load pulses and trigger edges so the tests can reason about them afterwards.
   always @(negedge clock) begin
      if (bus.O_core_load) loadCount = loadCount + 1;
      if (bus.O_trigger && !trigPrev) begin
         riseCyc = cycleNum;
         trigRises = trigRises + 1;
      end
      if (!bus.O_trigger && trigPrev) fallCyc = cycleNum;
      trigPrev = bus.O_trigger;
   end

   task automatic startJob(input logic [127:0] key, input logic [127:0] pt);
      @(negedge clock);
      bus.I_key = key;
      bus.I_textin = pt;
      bus.I_start = 1'b1;
      startCyc = cycleNum;
      @(negedge clock);
      bus.I_start = 1'b0;
   endtask

   task automatic atCycle(input int k);
      while (cycleNum < startCyc + k) @(negedge clock);
   endtask

   task automatic test_reset();
      @(negedge clock);
      checkCount++;
      if ({bus.O_ready, bus.O_busy, bus.O_done, bus.O_timeout_err, bus.O_trigger, bus.O_core_load} !== 6'b100000) begin
         failCount++;
         $display("[TB] FAIL reset_flags: got %b want 100000", {bus.O_ready, bus.O_busy, bus.O_done, bus.O_timeout_err, bus.O_trigger, bus.O_core_load});
      end else passCount++;
      checkCount++;
      if ({bus.O_cipherout, bus.O_cycles, bus.O_core_key, bus.O_core_data} !== '0) begin
         failCount++;
         $display("[TB] FAIL reset_data: got cipher %h cycles %0d key %h data %h want all zero", bus.O_cipherout, bus.O_cycles, bus.O_core_key, bus.O_core_data);
      end else passCount++;
      resetn = 1'b1;
      @(negedge clock);
      checkCount++;
      if (bus.O_ready !== 1'b1 || busS.O_ready !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL post_reset_ready: got %b/%b want 1/1", bus.O_ready, busS.O_ready);
      end else passCount++;
   endtask

   task automatic test_nominal();
      int loadsBefore;
      loadsBefore = loadCount;
      busyLen = 10;
      coreResult = Ct;
      bus.I_trig_delay = '0;
      bus.I_timeout = '0;
      startJob(Key, Pt);
      checkCount++;
      if ({bus.O_core_load, bus.O_busy, bus.O_ready} !== 3'b110) begin
         failCount++;
         $display("[TB] FAIL nominal_load_cycle: got load/busy/ready %b want 110", {bus.O_core_load, bus.O_busy, bus.O_ready});
      end else passCount++;
      checkCount++;
      if (bus.O_core_key !== Key || bus.O_core_data !== Pt) begin
         failCount++;
         $display("[TB] FAIL nominal_latch: got key %h data %h want %h %h", bus.O_core_key, bus.O_core_data, Key, Pt);
      end else passCount++;
      atCycle(2);
      checkCount++;
      if (bus.O_core_load !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL nominal_load_width: got %b want 0", bus.O_core_load);
      end else passCount++;
      atCycle(3);
      bus.I_key = ~Key;
      bus.I_textin = ~Pt;
      atCycle(12);
      checkCount++;
      if (bus.O_done !== 1'b0 || bus.O_ready !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL nominal_early_done: got done %b ready %b want 0 0", bus.O_done, bus.O_ready);
      end else passCount++;
      atCycle(13);
      checkCount++;
      if ({bus.O_done, bus.O_ready, bus.O_busy, bus.O_timeout_err} !== 4'b1100) begin
         failCount++;
         $display("[TB] FAIL nominal_status: got done/ready/busy/err %b want 1100", {bus.O_done, bus.O_ready, bus.O_busy, bus.O_timeout_err});
      end else passCount++;
      checkCount++;
      if (bus.O_cipherout !== Ct) begin
         failCount++;
         $display("[TB] FAIL nominal_cipher: got %h want %h", bus.O_cipherout, Ct);
      end else passCount++;
      checkCount++;
      if (bus.O_cycles !== 16'd10) begin
         failCount++;
         $display("[TB] FAIL nominal_cycles: got %0d want 10", bus.O_cycles);
      end else passCount++;
      checkCount++;
      if (bus.O_core_key !== Key || loadCount - loadsBefore !== 1) begin
         failCount++;
         $display("[TB] FAIL nominal_key_hold: got key %h loads %0d want %h 1", bus.O_core_key, loadCount - loadsBefore, Key);
      end else passCount++;
   endtask

   task automatic test_timeout();
      busyLen = 1;
      holdBusy = 1'b1;
      coreResult = ~Ct;
      bus.I_timeout = 16'd5;
      bus.I_trig_delay = '0;
      startJob(Key, Pt);
      atCycle(6);
      checkCount++;
      if (bus.O_done !== 1'b0 || bus.O_trigger !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL timeout_running: got done %b trig %b want 0 1", bus.O_done, bus.O_trigger);
      end else passCount++;
      atCycle(7);
      checkCount++;
      if ({bus.O_done, bus.O_timeout_err, bus.O_ready, bus.O_trigger} !== 4'b1110) begin
         failCount++;
         $display("[TB] FAIL timeout_status: got done/err/ready/trig %b want 1110", {bus.O_done, bus.O_timeout_err, bus.O_ready, bus.O_trigger});
      end else passCount++;
      checkCount++;
      if (bus.O_cipherout !== Ct) begin
         failCount++;
         $display("[TB] FAIL timeout_cipher_kept: got %h want %h", bus.O_cipherout, Ct);
      end else passCount++;
      checkCount++;
      if (bus.O_cycles !== 16'd5) begin
         failCount++;
         $display("[TB] FAIL timeout_cycles: got %0d want 5", bus.O_cycles);
      end else passCount++;
      holdBusy = 1'b0;
      bus.I_timeout = '0;
      atCycle(10);
   endtask

   task automatic test_trigger();
      int risesBefore;
      busyLen = 10;
      coreResult = Ct;
      bus.I_trig_delay = 8'd3;
      startJob(Key, Pt);
      atCycle(15);
      checkCount++;
      if (riseCyc - startCyc !== 5) begin
         failCount++;
         $display("[TB] FAIL trigger_rise: got cycle %0d want 5", riseCyc - startCyc);
      end else passCount++;
      checkCount++;
      if (fallCyc - startCyc !== 13) begin
         failCount++;
         $display("[TB] FAIL trigger_fall: got cycle %0d want 13", fallCyc - startCyc);
      end else passCount++;
      risesBefore = trigRises;
      bus.I_trig_delay = 8'd20;
      startJob(Key, Pt);
      atCycle(26);
      checkCount++;
      if (trigRises !== risesBefore || bus.O_trigger !== 1'b0 || bus.O_done !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL trigger_long_delay: got rises %0d trig %b done %b want 0 0 1", trigRises - risesBefore, bus.O_trigger, bus.O_done);
      end else passCount++;
      bus.I_trig_delay = '0;
   endtask

   task automatic test_back_to_back();
      int loadsBefore;
      loadsBefore = loadCount;
      busyLen = 10;
      coreResult = Ct;
      startJob(Key, Pt);
      atCycle(5);
      bus.I_key = ~Key;
      bus.I_textin = ~Pt;
      bus.I_start = 1'b1;
      atCycle(6);
      bus.I_start = 1'b0;
      atCycle(12);
      bus.I_start = 1'b1;
      atCycle(13);
      bus.I_start = 1'b0;
      atCycle(15);
      checkCount++;
      if (loadCount - loadsBefore !== 1) begin
         failCount++;
         $display("[TB] FAIL b2b_loads: got %0d want 1", loadCount - loadsBefore);
      end else passCount++;
      checkCount++;
      if (bus.O_core_key !== Key || bus.O_cipherout !== Ct) begin
         failCount++;
         $display("[TB] FAIL b2b_first_job: got key %h cipher %h want %h %h", bus.O_core_key, bus.O_cipherout, Key, Ct);
      end else passCount++;
      checkCount++;
      if ({bus.O_ready, bus.O_busy, bus.O_done} !== 3'b101) begin
         failCount++;
         $display("[TB] FAIL b2b_idle: got ready/busy/done %b want 101", {bus.O_ready, bus.O_busy, bus.O_done});
      end else passCount++;
   endtask

   task automatic test_abort();
      busyLen = 10;
      coreResult = ~Ct;
      startJob(Key, Pt);
      atCycle(4);
      checkCount++;
      if (bus.O_trigger !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL abort_trig_before: got %b want 1", bus.O_trigger);
      end else passCount++;
      bus.I_abort = 1'b1;
      atCycle(5);
      bus.I_abort = 1'b0;
      checkCount++;
      if ({bus.O_ready, bus.O_busy, bus.O_done, bus.O_trigger} !== 4'b1000) begin
         failCount++;
         $display("[TB] FAIL abort_status: got ready/busy/done/trig %b want 1000", {bus.O_ready, bus.O_busy, bus.O_done, bus.O_trigger});
      end else passCount++;
      checkCount++;
      if (bus.O_cipherout !== Ct || bus.O_cycles !== 16'd10) begin
         failCount++;
         $display("[TB] FAIL abort_kept: got cipher %h cycles %0d want %h 10", bus.O_cipherout, bus.O_cycles, Ct);
      end else passCount++;
      atCycle(16);
      bus.I_abort = 1'b1;
      atCycle(17);
      bus.I_abort = 1'b0;
      checkCount++;
      if (bus.O_ready !== 1'b1 || bus.O_done !== 1'b0 || bus.O_cipherout !== Ct) begin
         failCount++;
         $display("[TB] FAIL abort_idle: got ready %b done %b cipher %h want 1 0 %h", bus.O_ready, bus.O_done, bus.O_cipherout, Ct);
      end else passCount++;
   endtask

   task automatic test_reset_mid_run();
      busyLen = 10;
      coreResult = Ct;
      startJob(Key, Pt);
      atCycle(6);
      #1;
      resetn = 1'b0;
      coreKill = 1'b1;
      #1;
      checkCount++;
      if ({bus.O_ready, bus.O_busy, bus.O_done, bus.O_timeout_err, bus.O_trigger, bus.O_core_load} !== 6'b100000) begin
         failCount++;
         $display("[TB] FAIL midreset_flags: got %b want 100000", {bus.O_ready, bus.O_busy, bus.O_done, bus.O_timeout_err, bus.O_trigger, bus.O_core_load});
      end else passCount++;
      checkCount++;
      if ({bus.O_cipherout, bus.O_cycles, bus.O_core_key, bus.O_core_data} !== '0) begin
         failCount++;
         $display("[TB] FAIL midreset_data: got cipher %h cycles %0d key %h want zero", bus.O_cipherout, bus.O_cycles, bus.O_core_key);
      end else passCount++;
      @(negedge clock);
      @(negedge clock);
      coreKill = 1'b0;
      resetn = 1'b1;
      startJob(Key, Pt);
      atCycle(13);
      checkCount++;
      if (bus.O_done !== 1'b1 || bus.O_cipherout !== Ct || bus.O_cycles !== 16'd10) begin
         failCount++;
         $display("[TB] FAIL post_reset_job: got done %b cipher %h cycles %0d want 1 %h 10", bus.O_done, bus.O_cipherout, bus.O_cycles, Ct);
      end else passCount++;
   endtask

   task automatic test_saturation();
      int waited;
      @(negedge clock);
      busS.I_key = Key;
      busS.I_textin = Pt;
      busS.I_start = 1'b1;
      @(negedge clock);
      busS.I_start = 1'b0;
      busS.I_core_busy = 1'b1;
      busS.I_core_data = Junk;
      repeat (20) @(negedge clock);
      busS.I_core_busy = 1'b0;
      busS.I_core_data = Ct;
      waited = 0;
      while (busS.O_done !== 1'b1 && waited < 10) begin
         @(negedge clock);
         waited++;
      end
      checkCount++;
      if (busS.O_done !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL sat_done_wait: got done %b after %0d cycles want 1", busS.O_done, waited);
      end else passCount++;
      checkCount++;
      if (busS.O_cycles !== 4'd15) begin
         failCount++;
         $display("[TB] FAIL sat_cycles: got %0d want 15", busS.O_cycles);
      end else passCount++;
      checkCount++;
      if (busS.O_timeout_err !== 1'b0 || busS.O_cipherout !== Ct) begin
         failCount++;
         $display("[TB] FAIL sat_result: got err %b cipher %h want 0 %h", busS.O_timeout_err, busS.O_cipherout, Ct);
      end else passCount++;
   endtask

   // Drives every test in order, then prints the one summary line.
   initial begin
      bus.I_start = 1'b0;
      bus.I_abort = 1'b0;
      bus.I_key = '0;
      bus.I_textin = '0;
      bus.I_timeout = '0;
      bus.I_trig_delay = '0;
      bus.I_core_busy = 1'b0;
      bus.I_core_data = '0;
      busS.I_start = 1'b0;
      busS.I_abort = 1'b0;
      busS.I_key = '0;
      busS.I_textin = '0;
      busS.I_timeout = '0;
      busS.I_trig_delay = '0;
      busS.I_core_busy = 1'b0;
      busS.I_core_data = '0;
      test_reset();
      test_nominal();
      test_timeout();
      test_trigger();
      test_back_to_back();
      test_abort();
      test_reset_mid_run();
      test_saturation();
      if (failCount != 0) $display("[TB] %0d comparisons did not match", failCount);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
